vm_change_ctrl: RTL and testbench

//  Change-return sequencer for the vending machine. Takes a change amount in cents from the vend FSM,

---
 rtl/vm_change_ctrl_pkg.sv | 34 +++
 rtl/vm_change_ctrl_if.sv | 9 +
 rtl/vm_change_ctrl_coin_pick.sv | 28 ++
 rtl/vm_change_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_vm_change_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vm_change_ctrl_pkg.sv
// Shared types and coin constants for the vending-machine change path.
// Used by vm_change_ctrl, its coin picker and the hopper-facing interface.
package vm_change_ctrl_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    NICKEL  = 2'b01,
    DIME    = 2'b10,
    QUARTER = 2'b11
  } coin_e;

  localparam int unsigned VAL_NICKEL  = 5;
  localparam int unsigned VAL_DIME    = 10;
  localparam int unsigned VAL_QUARTER = 25;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SELECT = 3'd2,
    ST_EJECT  = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAULT  = 3'd5
  } chg_state_e;

  function automatic logic [4:0] coin_value(input coin_e c);
    case (c)
      NICKEL:  coin_value = 5'(VAL_NICKEL);
      DIME:    coin_value = 5'(VAL_DIME);
      QUARTER: coin_value = 5'(VAL_QUARTER);
      default: coin_value = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vm_change_ctrl_if.sv
// Coin eject handshake between the change sequencer (master) and the hopper (slave).
interface vm_change_ctrl_if;
  logic                      eject_valid;
  vm_change_ctrl_pkg::coin_e eject_coin;
  logic                      eject_ack;

  modport master (output eject_valid, output eject_coin, input eject_ack);
  modport slave  (input eject_valid, input eject_coin, output eject_ack);
endinterface

// File: rtl/vm_change_ctrl_coin_pick.sv
// Greedy coin chooser: largest coin whose value fits the remainder and whose tube is non-empty.
module vm_coin_pick
  import vm_change_ctrl_pkg::*;
#(
  parameter int AMT_W = 16,
  parameter int CNT_W = 8
) (
  input  logic [AMT_W-1:0] rem_i,
  input  logic [CNT_W-1:0] cnt_q_i,
  input  logic [CNT_W-1:0] cnt_d_i,
  input  logic [CNT_W-1:0] cnt_n_i,
  output coin_e            coin_o
);

  always_comb begin
    coin_o = NONE;
    if (rem_i >= AMT_W'(VAL_QUARTER) && cnt_q_i != {CNT_W{1'b0}}) begin
      coin_o = QUARTER;
    end else if (rem_i >= AMT_W'(VAL_DIME) && cnt_d_i != {CNT_W{1'b0}}) begin
      coin_o = DIME;
    end else if (rem_i >= AMT_W'(VAL_NICKEL) && cnt_n_i != {CNT_W{1'b0}}) begin
      coin_o = NICKEL;
    end else begin
      coin_o = NONE;
    end
  end

endmodule

// File: rtl/vm_change_ctrl.sv
// Change-return sequencer: meters coins out of quarter/dime/nickel tubes and tracks inventory.
// Optional VM_EXACT_CHANGE_EN adds a greedy dry-run so change is paid in full or not at all.
module vm_change_ctrl
  import vm_change_ctrl_pkg::*;
#(
  parameter int AMT_W   = 16,
  parameter int CNT_W   = 8,
  parameter int INV_MAX = 200,
  parameter int ACK_TMO = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [AMT_W-1:0] amount_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [AMT_W-1:0] remainder_o,
  output logic             short_chg_o,
  output logic             fault_o,
  input  logic             restock_valid_i,
  input  coin_e            restock_coin_i,
  input  logic [CNT_W-1:0] restock_qty_i,
  output logic [CNT_W-1:0] inv_q_o,
  output logic [CNT_W-1:0] inv_d_o,
  output logic [CNT_W-1:0] inv_n_o,
  vm_change_ctrl_if.master ej
);

  localparam int TMO_W = $clog2(ACK_TMO + 1);

  chg_state_e       state_q;
  logic [AMT_W-1:0] rem_q, rem_out_q;
  logic [TMO_W-1:0] tmo_q;
  logic             busy_q, done_q, short_q, fault_q, ej_valid_q;
  coin_e            ej_coin_q, pick_s;
  logic [CNT_W-1:0] cnt_qtr_q, cnt_dime_q, cnt_nck_q;
  logic [CNT_W-1:0] cnt_qtr_d, cnt_dime_d, cnt_nck_d;
  logic             fire_s;

  vm_coin_pick #(.AMT_W(AMT_W), .CNT_W(CNT_W)) u_pick (
    .rem_i(rem_q), .cnt_q_i(cnt_qtr_q), .cnt_d_i(cnt_dime_q), .cnt_n_i(cnt_nck_q), .coin_o(pick_s)
  );

`ifdef VM_EXACT_CHANGE_EN
  logic [AMT_W-1:0] amount_q;
  logic [CNT_W-1:0] sh_qtr_q, sh_dime_q, sh_nck_q;
  coin_e            sh_pick_s;

  vm_coin_pick #(.AMT_W(AMT_W), .CNT_W(CNT_W)) u_pick_shadow (
    .rem_i(rem_q), .cnt_q_i(sh_qtr_q), .cnt_d_i(sh_dime_q), .cnt_n_i(sh_nck_q), .coin_o(sh_pick_s)
  );
`endif

  assign fire_s = (state_q == ST_EJECT) && ej.eject_ack;

  // Saturating tube update; a coin is only ever chosen from a non-empty tube, so dec never underflows.
  function automatic logic [CNT_W-1:0] tube_next(input logic [CNT_W-1:0] cnt, input logic add,
                                                 input logic [CNT_W-1:0] qty, input logic dec);
    logic [CNT_W+1:0] sum;
    sum = {2'b00, cnt} + (add ? {2'b00, qty} : {(CNT_W+2){1'b0}}) - {{(CNT_W+1){1'b0}}, dec};
    if (sum > (CNT_W+2)'(INV_MAX)) begin
      tube_next = CNT_W'(INV_MAX);
    end else begin
      tube_next = sum[CNT_W-1:0];
    end
  endfunction

  // Next tube counts from restock and completed ejects.
  always_comb begin
    cnt_qtr_d  = tube_next(cnt_qtr_q, restock_valid_i && restock_coin_i == QUARTER, restock_qty_i,
                           fire_s && ej_coin_q == QUARTER);
    cnt_dime_d = tube_next(cnt_dime_q, restock_valid_i && restock_coin_i == DIME, restock_qty_i,
                           fire_s && ej_coin_q == DIME);
    cnt_nck_d  = tube_next(cnt_nck_q, restock_valid_i && restock_coin_i == NICKEL, restock_qty_i,
                           fire_s && ej_coin_q == NICKEL);
  end

  // Tube inventory registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_qtr_q  <= {CNT_W{1'b0}};
      cnt_dime_q <= {CNT_W{1'b0}};
      cnt_nck_q  <= {CNT_W{1'b0}};
    end else begin
      cnt_qtr_q  <= cnt_qtr_d;
      cnt_dime_q <= cnt_dime_d;
      cnt_nck_q  <= cnt_nck_d;
    end
  end

  // Change sequencing FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rem_q      <= {AMT_W{1'b0}};
      rem_out_q  <= {AMT_W{1'b0}};
      tmo_q      <= {TMO_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      short_q    <= 1'b0;
      fault_q    <= 1'b0;
      ej_valid_q <= 1'b0;
      ej_coin_q  <= NONE;
`ifdef VM_EXACT_CHANGE_EN
      amount_q   <= {AMT_W{1'b0}};
      sh_qtr_q   <= {CNT_W{1'b0}};
      sh_dime_q  <= {CNT_W{1'b0}};
      sh_nck_q   <= {CNT_W{1'b0}};
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            rem_q  <= amount_i;
            busy_q <= 1'b1;
`ifdef VM_EXACT_CHANGE_EN
            amount_q  <= amount_i;
            sh_qtr_q  <= cnt_qtr_q;
            sh_dime_q <= cnt_dime_q;
            sh_nck_q  <= cnt_nck_q;
            state_q   <= ST_CHECK;
`else
            state_q   <= ST_SELECT;
`endif
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CHECK: begin
`ifdef VM_EXACT_CHANGE_EN
          // Dry-run consumes rem_q; it is reloaded from amount_q before real ejects start.
          if (rem_q == {AMT_W{1'b0}}) begin
            rem_q   <= amount_q;
            state_q <= ST_SELECT;
          end else if (sh_pick_s == NONE) begin
            done_q    <= 1'b1;
            rem_out_q <= amount_q;
            short_q   <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            rem_q <= rem_q - AMT_W'(coin_value(sh_pick_s));
            case (sh_pick_s)
              QUARTER: sh_qtr_q  <= sh_qtr_q - 8'(1);
              DIME:    sh_dime_q <= sh_dime_q - 8'(1);
              NICKEL:  sh_nck_q  <= sh_nck_q - 8'(1);
              default: sh_nck_q  <= sh_nck_q;
            endcase
          end
`else
          state_q <= ST_IDLE;
`endif
        end
        ST_SELECT: begin
          if (pick_s == NONE) begin
            done_q    <= 1'b1;
            rem_out_q <= rem_q;
            short_q   <= (rem_q != {AMT_W{1'b0}});
            state_q   <= ST_DONE;
          end else begin
            ej_valid_q <= 1'b1;
            ej_coin_q  <= pick_s;
            tmo_q      <= {TMO_W{1'b0}};
            state_q    <= ST_EJECT;
          end
        end
        ST_EJECT: begin
          if (ej.eject_ack) begin
            ej_valid_q <= 1'b0;
            rem_q      <= rem_q - AMT_W'(coin_value(ej_coin_q));
            state_q    <= ST_SELECT;
          end else if (tmo_q == TMO_W'(ACK_TMO - 1)) begin
            ej_valid_q <= 1'b0;
            fault_q    <= 1'b1;
            state_q    <= ST_FAULT;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_FAULT: state_q <= ST_FAULT;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign remainder_o    = rem_out_q;
  assign short_chg_o    = short_q;
  assign fault_o        = fault_q;
  assign ej.eject_valid = ej_valid_q;
  assign ej.eject_coin  = ej_coin_q;
  assign inv_q_o        = cnt_qtr_q;
  assign inv_d_o        = cnt_dime_q;
  assign inv_n_o        = cnt_nck_q;

endmodule

// File: tb/tb_vm_change_ctrl.sv
// Scoreboard bench for vm_change_ctrl: greedy change model in plain arithmetic, random and directed cases.
module tb_vm_change_ctrl;
  import vm_change_ctrl_pkg::*;

  localparam int AMT_W = 16, CNT_W = 8, INV_MAX = 200, ACK_TMO = 255;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, restock_valid = 1'b0;
  logic [AMT_W-1:0] amount = '0;
  coin_e restock_coin = NONE;
  logic [CNT_W-1:0] restock_qty = '0;
  logic busy, done, short_chg, fault;
  logic [AMT_W-1:0] remainder;
  logic [CNT_W-1:0] inv_q, inv_d, inv_n;

  vm_change_ctrl_if ej_if ();

  vm_change_ctrl #(.AMT_W(AMT_W), .CNT_W(CNT_W), .INV_MAX(INV_MAX), .ACK_TMO(ACK_TMO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .amount_i(amount), .busy_o(busy), .done_o(done),
    .remainder_o(remainder), .short_chg_o(short_chg), .fault_o(fault),
    .restock_valid_i(restock_valid), .restock_coin_i(restock_coin), .restock_qty_i(restock_qty),
    .inv_q_o(inv_q), .inv_d_o(inv_d), .inv_n_o(inv_n), .ej(ej_if.master)
  );

  always #5 clk = ~clk;

  typedef struct { int rem; int short_c; } done_t;
  int    exp_coin_q[$];
  done_t exp_done_q[$];
  int    inv_m[4];
  int    val_m[4] = '{0, 5, 10, 25};
  int    tests_run = 0, failed = 0;
  int    ack_mode = 0;  // 0 random ack, 1 never ack, 2 driven by test

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    ej_if.eject_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_mode == 0) ej_if.eject_ack = ej_if.eject_valid && ($urandom_range(0, 2) != 0);
      else if (ack_mode == 1) ej_if.eject_ack = 1'b0;
    end
  end

  // Monitor: pop expectations whenever a coin handshake or done pulse is presented
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (ej_if.eject_valid && ej_if.eject_ack) begin
          if (exp_coin_q.size() == 0) check("unexpected_eject", int'(ej_if.eject_coin), 0);
          else check("eject_coin", int'(ej_if.eject_coin), exp_coin_q.pop_front());
        end
        if (done) begin
          if (exp_done_q.size() == 0) check("unexpected_done", 1, 0);
          else begin
            done_t d;
            d = exp_done_q.pop_front();
            check("remainder", int'(remainder), d.rem);
            check("short_chg", int'(short_chg), d.short_c);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got 0 expected 1");
    $fatal(1);
  end

  task automatic check_inv(input string tag);
    check({tag, "_inv_q"}, int'(inv_q), inv_m[3]);
    check({tag, "_inv_d"}, int'(inv_d), inv_m[2]);
    check({tag, "_inv_n"}, int'(inv_n), inv_m[1]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_coin_q.delete();
    exp_done_q.delete();
    inv_m = '{0, 0, 0, 0};
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_valid", int'(ej_if.eject_valid), 0);
    check("rst_rem", int'(remainder), 0);
    check("rst_short", int'(short_chg), 0);
    check_inv("rst");
  endtask

  task automatic restock(input coin_e c, input int qty);
    @(negedge clk);
    restock_valid = 1'b1;
    restock_coin = c;
    restock_qty = CNT_W'(qty);
    if (c != NONE) inv_m[int'(c)] = (inv_m[int'(c)] + qty > INV_MAX) ? INV_MAX : inv_m[int'(c)] + qty;
    @(negedge clk);
    restock_valid = 1'b0;
  endtask

  // Reference: greedy largest-fitting coin from available stock; all-or-nothing with exact change
  task automatic issue_start(input int amt);
    int r, k;
    int c[4];
    int picked[$];
    done_t d;
    r = amt;
    c = inv_m;
    for (int it = 0; it < 1000; it++) begin
      k = 0;
      for (int j = 3; j >= 1; j--) if (k == 0 && val_m[j] <= r && c[j] > 0) k = j;
      if (k == 0) break;
      picked.push_back(k);
      c[k]--;
      r -= val_m[k];
    end
`ifdef VM_EXACT_CHANGE_EN
    if (r != 0) begin
      picked.delete();
      c = inv_m;
      r = amt;
    end
`endif
    inv_m = c;
    foreach (picked[i]) exp_coin_q.push_back(picked[i]);
    d.rem = r;
    d.short_c = (r != 0) ? 1 : 0;
    exp_done_q.push_back(d);
    @(negedge clk);
    start = 1'b1;
    amount = AMT_W'(amt);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int seen = 0;
    for (int k = 0; k < 3000 && seen == 0; k++) begin
      @(negedge clk);
      #1;
      if (done) seen = 1;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_coins_left"}, exp_coin_q.size(), 0);
    check_inv(tag);
  endtask

  task automatic wait_valid(input string tag);
    int seen = 0;
    for (int k = 0; k < 100 && seen == 0; k++) begin
      @(negedge clk);
      #1;
      if (ej_if.eject_valid) seen = 1;
    end
    check({tag, "_valid_seen"}, seen, 1);
  endtask

  initial begin
    int cnt, seen;
    do_reset();

    // 1: full change from stocked tubes
    restock(QUARTER, 4); restock(DIME, 4); restock(NICKEL, 4);
    issue_start(40);
    wait_done("t1");

    // 2: partial change when tubes run short
    do_reset();
    restock(QUARTER, 1);
    issue_start(35);
    wait_done("t2");

    // 3: zero amount latency, then non-multiple of five
    issue_start(0);
    #1;
    check("t3_busy_lat", int'(busy), 1);
    check("t3_done_early", int'(done), 0);
    @(negedge clk);
    #1;
    check("t3_done_lat", int'(done), 1);
    restock(NICKEL, 2);
    issue_start(7);
    wait_done("t3b");

    // 4: ack timeout -> sticky fault
    do_reset();
    restock(QUARTER, 1);
    ack_mode = 1;
    issue_start(25);
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (ej_if.eject_valid) cnt++;
      if (fault) break;
    end
    check("t4_tmo_cycles", cnt, ACK_TMO);
    check("t4_fault", int'(fault), 1);
    check("t4_valid", int'(ej_if.eject_valid), 0);
    check("t4_busy", int'(busy), 1);
    ack_mode = 0;
    do_reset();

    // 5: same-cycle restock and ack on one tube, start while busy ignored
    restock(DIME, INV_MAX - 2);
    ack_mode = 2;
    ej_if.eject_ack = 1'b0;
    issue_start(10);
    @(negedge clk);
    start = 1'b1;
    amount = AMT_W'(25);
    @(negedge clk);
    start = 1'b0;
    wait_valid("t5");
    @(negedge clk);
    ej_if.eject_ack = 1'b1;
    restock_valid = 1'b1;
    restock_coin = DIME;
    restock_qty = CNT_W'(5);
    inv_m[2] = (inv_m[2] + 5 > INV_MAX) ? INV_MAX : inv_m[2] + 5;
    @(negedge clk);
    ej_if.eject_ack = 1'b0;
    restock_valid = 1'b0;
    ack_mode = 0;
    wait_done("t5");
    check("t5_dime_sat", int'(inv_d), INV_MAX);

    // 6: reset during eject
    do_reset();
    ack_mode = 2;
    ej_if.eject_ack = 1'b0;
    restock(QUARTER, 2);
    issue_start(50);
    wait_valid("t6");
    @(negedge clk);
    rst = 1'b1;
    exp_coin_q.delete();
    exp_done_q.delete();
    inv_m = '{0, 0, 0, 0};
    @(negedge clk);
    #1;
    check("t6_valid", int'(ej_if.eject_valid), 0);
    check("t6_busy", int'(busy), 0);
    check_inv("t6");
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (done) seen = 1;
    end
    check("t6_no_done", seen, 0);
    ack_mode = 0;
    restock(NICKEL, 3);
    issue_start(10);
    wait_done("t6b");

    // Random phase
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 1) == 1) restock(coin_e'($urandom_range(0, 3)), $urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) restock(coin_e'($urandom_range(1, 3)), 255);
      issue_start($urandom_range(0, 120));
      wait_done("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
